// File: rtl/iq_pair_packer.sv
// Packs Q-then-I sample pairs into {I,Q} words in a first-word-fall-through FIFO; optional drop counter via IQ_PACKER_OVF_CNT_EN.
// Latency: a word is on m_data with m_valid the cycle after its I sample edge (FIFO empty).
// Backpressure: m_ready low holds the head stable; a pair arriving at a full FIFO without a same-cycle pop is dropped and flagged in ovf.
module iq_pair_packer #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [15:0]   in,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [31:0]   m_data,
    output logic [AW:0]   fill,
    output logic          ovf,
    input  logic          ovf_clr,
    output logic [15:0]   ovf_count
);

    typedef enum logic {IDLE, HAVE_Q} state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [15:0]   q_hold_q, q_hold_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fill_q, fill_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   mem_q [DEPTH];

    logic push_req;
    logic push;
    logic pop;
    logic drop;

    // Pair tracker: a Q without an I on the next cycle is discarded.
    always_comb begin
        state_d  = state_q;
        q_hold_d = q_hold_q;
        push_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    q_hold_d = in;
                    state_d  = HAVE_Q;
                end
            end
            HAVE_Q: begin
                push_req = in_valid;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop  = (fill_q != '0) && m_ready;
    assign push = push_req && ((fill_q != FULL_CNT) || pop);
    assign drop = push_req && !push;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      fill_d = fill_q + (AW+1)'(1);
        else if (pop && !push) fill_d = fill_q - (AW+1)'(1);
        if (ovf_clr) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            q_hold_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_hold_q <= q_hold_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; validity is tracked solely by fill.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in, q_hold_q};
    end

    assign m_data  = mem_q[rd_ptr_q];
    assign m_valid = (fill_q != '0);
    assign fill    = fill_q;
    assign ovf     = ovf_q;

`ifdef IQ_PACKER_OVF_CNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (ovf_clr) ovf_cnt_d = '0;
        if (drop) begin
            if (ovf_clr)                   ovf_cnt_d = 16'd1;
            else if (ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ovf_cnt_q <= '0;
        else       ovf_cnt_q <= ovf_cnt_d;
    end

    assign ovf_count = ovf_cnt_q;
`else
    assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_iq_pair_packer.sv
// Directed bench for iq_pair_packer; inputs change 1ns after the rising edge, outputs are checked there too.
module tb_iq_pair_packer;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

`ifdef IQ_PACKER_OVF_CNT_EN
    localparam logic [15:0] DROP1_CNT = 16'd1;
`else
    localparam logic [15:0] DROP1_CNT = 16'd0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [15:0]   in;
    logic          m_valid;
    logic          m_ready;
    logic [31:0]   m_data;
    logic [AW:0]   fill;
    logic          ovf;
    logic          ovf_clr;
    logic [15:0]   ovf_count;

    int errors = 0;
    int checks = 0;

    iq_pair_packer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in        (in),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .fill      (fill),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .ovf_count (ovf_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_pair(input logic [15:0] q, input logic [15:0] i);
        in_valid = 1'b1;
        in       = q;
        tick();
        in       = i;
        tick();
        in_valid = 1'b0;
        in       = 16'h0;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in       = 16'h0;
        m_ready  = 1'b0;
        ovf_clr  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_ovfcnt", 32'(ovf_count), 32'd0);

        // Single pair, consumer ready: word visible for exactly one cycle.
        m_ready = 1'b1;
        send_pair(16'h1234, 16'hABCD);
        chk("single_valid", 32'(m_valid), 32'd1);
        chk("single_data", m_data, 32'hABCD1234);
        chk("single_fill1", 32'(fill), 32'd1);
        tick();
        chk("single_valid_off", 32'(m_valid), 32'd0);
        chk("single_fill0", 32'(fill), 32'd0);

        // Orphan Q followed by a real pair.
        m_ready  = 1'b0;
        in_valid = 1'b1;
        in       = 16'h7FFF;
        tick();
        in_valid = 1'b0;
        tick();
        chk("orphan_nopush", 32'(fill), 32'd0);
        send_pair(16'h0001, 16'h0002);
        chk("orphan_fill", 32'(fill), 32'd1);
        chk("orphan_data", m_data, 32'h00020001);
        m_ready = 1'b1;
        tick();
        chk("orphan_drained", 32'(m_valid), 32'd0);
        m_ready = 1'b0;

        // 17 pairs into a 16-deep FIFO with no consumer.
        for (int k = 0; k < 17; k++) send_pair(16'h1000 + 16'(k), 16'h2000 + 16'(k));
        chk("ovf_fill", 32'(fill), 32'd16);
        chk("ovf_flag", 32'(ovf), 32'd1);
        chk("ovf_cnt", 32'(ovf_count), 32'(DROP1_CNT));
        tick();
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_data", m_data, 32'h20001000);
        m_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("drain_%0d", k), m_data, {16'h2000 + 16'(k), 16'h1000 + 16'(k)});
            tick();
        end
        chk("drain_fill0", 32'(fill), 32'd0);
        chk("drain_empty", 32'(m_valid), 32'd0);
        chk("ovf_sticky", 32'(ovf), 32'd1);
        m_ready = 1'b0;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("clr_ovf", 32'(ovf), 32'd0);
        chk("clr_cnt", 32'(ovf_count), 32'd0);

        // Full FIFO with a pop on the same edge as the I sample.
        for (int k = 0; k < 16; k++) send_pair(16'h3000 + 16'(k), 16'h4000 + 16'(k));
        chk("full_fill", 32'(fill), 32'd16);
        in_valid = 1'b1;
        in       = 16'h5555;
        tick();
        in      = 16'h6666;
        m_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("fullpop_fill", 32'(fill), 32'd16);
        chk("fullpop_ovf", 32'(ovf), 32'd0);
        chk("fullpop_head", m_data, 32'h40013001);
        for (int k = 1; k < 16; k++) begin
            chk($sformatf("fp_drain_%0d", k), m_data, {16'h4000 + 16'(k), 16'h3000 + 16'(k)});
            tick();
        end
        chk("fp_last", m_data, 32'h66665555);
        tick();
        chk("fp_empty", 32'(fill), 32'd0);
        m_ready = 1'b0;

        // Clear pulse coinciding with a dropped pair: set wins.
        for (int k = 0; k < 16; k++) send_pair(16'h7000 + 16'(k), 16'h7100 + 16'(k));
        in_valid = 1'b1;
        in       = 16'hAAAA;
        tick();
        in      = 16'hBBBB;
        ovf_clr = 1'b1;
        tick();
        ovf_clr  = 1'b0;
        in_valid = 1'b0;
        chk("coll_ovf", 32'(ovf), 32'd1);
        chk("coll_cnt", 32'(ovf_count), 32'(DROP1_CNT));
        chk("coll_fill", 32'(fill), 32'd16);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("coll_clr_ovf", 32'(ovf), 32'd0);
        chk("coll_clr_cnt", 32'(ovf_count), 32'd0);
        m_ready = 1'b1;
        for (int k = 0; k < 16; k++) tick();
        chk("coll_drained", 32'(fill), 32'd0);
        m_ready = 1'b0;

        // Reset with three words queued and a Q held; in_valid stays high through reset.
        send_pair(16'hC000, 16'hC001);
        send_pair(16'hC002, 16'hC003);
        send_pair(16'hC004, 16'hC005);
        chk("pre_rst_fill", 32'(fill), 32'd3);
        in_valid = 1'b1;
        in       = 16'hDEAD;
        tick();
        reset = 1'b1;
        in    = 16'hEEEE;
        tick();
        reset = 1'b0;
        chk("mid_rst_fill", 32'(fill), 32'd0);
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        in = 16'h0102;
        tick();
        in = 16'h0304;
        tick();
        in_valid = 1'b0;
        chk("post_rst_fill", 32'(fill), 32'd1);
        chk("post_rst_data", m_data, 32'h03040102);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
